// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole round engine.
package whack_pkg;

  // Round-engine states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_UP,
    ST_HIT,
    ST_MISS,
    ST_OVER
  } state_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11. In right-shift form the
  // feedback is bit0 ^ bit2 ^ bit3 ^ bit5.
  localparam int              LFSR_W        = 16;
  localparam logic [15:0]     LFSR_TAP_MASK = 16'h002D;

  // Width of a counter that must hold 0..div-1 (at least one bit).
  function automatic int tick_cnt_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/whack_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes its low bits as a random index.
module whack_lfsr
  import whack_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
  parameter int                OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] rnd_bits
);

  // A zero seed would lock the register, so fall back to 1.
  localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? 16'h0001 : SEED;

  logic [LFSR_W-1:0] lfsr_reg;
  logic              feedback;

  assign feedback = ^(lfsr_reg & LFSR_TAP_MASK);

  // Shift every cycle from reset onward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= SEED_SAFE;
    end else begin
      lfsr_reg <= {feedback, lfsr_reg[LFSR_W-1:1]};
    end
  end

  assign rnd_bits = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/whack_round_engine.sv
// Whack-a-mole game-round engine: picks a mole, runs a shrinking response
// window, scores hits and counts misses up to game over.
module whack_round_engine
  import whack_pkg::*;
#(
  parameter int          N_HOLES    = 4,
  parameter int          SCORE_W    = 4,
  parameter int          TICK_DIV   = 50_000_000,
  parameter int          T_INIT     = 9,
  parameter int          T_MIN      = 2,
  parameter int          MAX_MISSES = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                       systemClock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       key_valid,
  input  logic [$clog2(N_HOLES)-1:0] key_idx,
  output logic [N_HOLES-1:0]         mole,
  output logic [3:0]                 timer,
  output logic [SCORE_W-1:0]         score,
  output logic [3:0]                 misses,
  output logic                       hit_pulse,
  output logic                       miss_pulse,
  output logic                       game_over
);

  localparam int                   IDX_W     = $clog2(N_HOLES);
  localparam int                   CNT_W     = tick_cnt_w(TICK_DIV);
  localparam logic [CNT_W-1:0]     TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0]   SCORE_MAX = '1;
  localparam logic [3:0]           WIN_INIT  = 4'(T_INIT);
  localparam logic [3:0]           WIN_MIN   = 4'(T_MIN);
  localparam logic [3:0]           MISS_LIM  = 4'(MAX_MISSES);

  state_t             state_reg, state_next;
  logic [3:0]         window_reg, window_next;
  logic [3:0]         timer_reg, timer_next;
  logic [CNT_W-1:0]   tick_cnt_reg, tick_cnt_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [3:0]         misses_reg, misses_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [IDX_W-1:0]   raw_idx;
  logic               tick;

  whack_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (IDX_W)
  ) u_lfsr (
    .clk      (systemClock),
    .rst      (reset),
    .rnd_bits (raw_idx)
  );

  assign tick = (tick_cnt_reg == TICK_LAST);

  // State and datapath registers; idx_reg doubles as the previous-mole memory.
  always_ff @(posedge systemClock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      window_reg   <= WIN_INIT;
      timer_reg    <= '0;
      tick_cnt_reg <= '0;
      score_reg    <= '0;
      misses_reg   <= '0;
      idx_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      window_reg   <= window_next;
      timer_reg    <= timer_next;
      tick_cnt_reg <= tick_cnt_next;
      score_reg    <= score_next;
      misses_reg   <= misses_next;
      idx_reg      <= idx_next;
    end
  end

  // Next-state logic; score/misses/window update on leaving UP so they are
  // already valid while the hit/miss pulse is high.
  always_comb begin
    state_next    = state_reg;
    window_next   = window_reg;
    timer_next    = timer_reg;
    tick_cnt_next = tick_cnt_reg;
    score_next    = score_reg;
    misses_next   = misses_reg;
    idx_next      = idx_reg;

    case (state_reg)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_next  = ST_ARM;
          score_next  = '0;
          misses_next = '0;
          window_next = WIN_INIT;
        end
      end

      ST_ARM: begin
        // Never show the same hole twice in a row.
        idx_next      = (raw_idx == idx_reg) ? raw_idx + IDX_W'(1) : raw_idx;
        timer_next    = window_reg;
        tick_cnt_next = '0;
        state_next    = ST_UP;
      end

      ST_UP: begin
        tick_cnt_next = tick ? '0 : tick_cnt_reg + CNT_W'(1);
        if (key_valid) begin
          // A key press takes priority over a coincident final tick.
          if (key_idx == idx_reg) begin
            state_next  = ST_HIT;
            score_next  = (score_reg == SCORE_MAX) ? score_reg : score_reg + SCORE_W'(1);
            window_next = (window_reg > WIN_MIN) ? window_reg - 4'd1 : WIN_MIN;
          end else begin
            state_next  = ST_MISS;
            misses_next = misses_reg + 4'd1;
          end
        end else if (tick) begin
          timer_next = timer_reg - 4'd1;
          if (timer_reg == 4'd1) begin
            state_next  = ST_MISS;
            misses_next = misses_reg + 4'd1;
          end
        end
      end

      ST_HIT: begin
        state_next = ST_ARM;
      end

      ST_MISS: begin
        state_next = (misses_reg == MISS_LIM) ? ST_OVER : ST_ARM;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // One-hot mole decode, only while the mole is up.
  genvar gi;
  generate
    for (gi = 0; gi < N_HOLES; gi++) begin : g_mole
      assign mole[gi] = (state_reg == ST_UP) && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign timer      = timer_reg;
  assign score      = score_reg;
  assign misses     = misses_reg;
  assign hit_pulse  = (state_reg == ST_HIT);
  assign miss_pulse = (state_reg == ST_MISS);
  assign game_over  = (state_reg == ST_OVER);

endmodule

// File: doc/whack_round_engine.md
# whack_round_engine

Parametrised game-round core for the whack-a-mole design: N holes, pseudo-random non-repeating mole selection, a per-round response window that shrinks on every hit, saturating score, miss counting with game-over. Sits between the PS/2 keyboard decoder (key_valid/key_idx) and the display/audio logic (mole, timer, score, hit/miss pulses). It replaces the fixed 2-bit mole, timer and score blocks with one generalised engine.

## Interface
- N_HOLES, 4: number of holes; power of two, 2..16
- SCORE_W, 4: score width
- TICK_DIV, 50_000_000: systemClock cycles per timer tick
- T_INIT, 9: initial window in ticks, 1..15
- T_MIN, 2: minimum window in ticks, 1..T_INIT
- MAX_MISSES, 3: misses that end the game, 1..15
- LFSR_SEED, 16'hACE1: non-zero LFSR reset value

Ports:
- systemClock  in  1  system clock
- reset  in  1  asynchronous, active-high; all state to reset values
- start  in  1  level; begins a game from IDLE or OVER
- key_valid  in  1  one-cycle pulse, key press decoded
- key_idx  in  $clog2(N_HOLES)  hole index of pressed key
- mole  out  N_HOLES  one-hot active mole; 0 outside UP; reset 0
- timer  out  4  ticks remaining in current window; reset 0
- score  out  SCORE_W  hits this game; reset 0
- misses  out  4  misses this game; reset 0
- hit_pulse  out  1  one cycle per hit; reset 0
- miss_pulse  out  1  one cycle per miss; reset 0
- game_over  out  1  high while in OVER; reset 0

## Operation
- States: IDLE, ARM, UP, HIT, MISS, OVER. Reset enters IDLE.
- IDLE: start=1 -> ARM; score, misses cleared, window := T_INIT.
- ARM (1 cycle): idx := lfsr[log2(N_HOLES)-1:0]; if idx == previous idx, idx := (idx+1) mod N_HOLES. timer := window, tick counter cleared -> UP.
- UP: mole = 1<<idx. key_valid with key_idx==idx -> HIT; key_valid with key_idx!=idx -> MISS; tick with timer==1 -> timer 0, MISS; other ticks decrement timer.
- Simultaneous key_valid and final tick: key wins.
- HIT (1 cycle): hit_pulse=1; score+1, saturating at 2^SCORE_W-1; window := max(window-1, T_MIN) -> ARM.
- MISS (1 cycle): miss_pulse=1; misses+1; if new misses == MAX_MISSES -> OVER, else -> ARM.
- OVER: game_over=1, mole=0, score/misses held. start=1 -> ARM with clears as in IDLE.
- key_valid outside UP ignored. start outside IDLE/OVER ignored.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle from reset; never loaded with 0.
- Previous idx register resets to 0.

## Timing
- Tick: counter 0..TICK_DIV-1, wraps; tick asserted on wrap; counter runs only in UP, cleared in ARM.
- start sampled at edge -> ARM next cycle -> mole visible 2 cycles after start edge.
- key_valid at edge n in UP -> hit_pulse/miss_pulse and updated score/misses visible cycle n+1 -> next mole visible n+3 (ARM, UP).
- Timeout: mole visible for window*TICK_DIV cycles, then MISS.
- Reset asserted mid-round: outputs go to reset values immediately (async), no pulse emitted.

## Structure
- Package whack_pkg: state enum, LFSR width/tap constant, tick-counter width function.
- Sub-module whack_lfsr (16-bit, seed parameter, enable always 1), instantiated once.
- Remainder is a single FSM plus window, timer, tick, score, miss registers.

## Test plan
- Correct hits: TICK_DIV=4, press matching key each UP -> score 1,2,3; window 9,8,7 ticks; hit_pulse once each; no consecutive equal mole.
- Timeouts: start, never press -> MISS after 9*4=36 UP cycles each; after 3rd miss game_over=1, misses=3, mole=0.
- Wrong key: press key_idx != idx in UP -> miss_pulse, score unchanged, misses+1.
- Boundaries: SCORE_W=2, 5 hits -> score stays 3; window floors at T_MIN=2 after 7 hits; key_valid on same cycle as final tick -> HIT.
- Async reset mid-UP -> mole, score, misses, timer all 0, state IDLE, no pulse; start from OVER restarts with score 0, window 9.
- N_HOLES=8 -> mole always one-hot across 8 bits, all 8 indices seen within 200 rounds.
